wb_scoreboard: RTL
==================

# wb_scoreboard

Register-hazard scoreboard for the rv32i core. It tracks every destination register that has issued from decode but has not yet been written by the write-back stage. It stalls decode whenever a source operand depends on an in-flight write, or when the load-stall from write-back is asserted. It sits between decode and write-back and sequences instruction issue around the fixed-latency integer/upper/jump paths and the variable-latency load path.

## Interface

**Parameters**
- `CNT_W`, default 2: width of each per-register in-flight counter. Maximum in-flight writes per register is 2^CNT_W − 1.
- `MAX_LOADS`, default 2: maximum number of loads outstanding between issue and write-back.

**Ports**
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_issue_valid`  in  1  decode presents an instruction this cycle.
- `i_issue_rd_en`  in  1  the instruction writes rd.
- `i_issue_rd`  in  5  destination register.
- `i_issue_load`  in  1  the instruction is a load.
- `i_rs1_en`, `i_rs2_en`  in  1 each  the corresponding source is read.
- `i_rs1`, `i_rs2`  in  5 each  source register addresses.
- `i_load_stall`  in  1  write-back is waiting on load data.
- `i_rd_wvalid`  in  1  write-back register-file write strobe.
- `i_rd_waddr`  in  5  write-back destination address.
- `i_load_retire`  in  1  a load's data was accepted by write-back this cycle.
- `o_stall`  out  1  hold decode; the instruction is not issued.
- `o_issue`  out  1  the instruction is accepted this cycle.
- `o_pending`  out  32  bit n set when register n has ≥1 in-flight write; bit 0 is always 0.
- `o_loads_busy`  out  1  outstanding-load count equals `MAX_LOADS`.
- `o_err`  out  1  sticky protocol error.

## Operation

**State**
- 31 counters `cnt[1..31]`, each `CNT_W` bits wide.
- Outstanding-load counter `lcnt`, width $clog2(MAX_LOADS+1).
- Sticky `err` flag.
- Register x0 is never tracked. Any issue or retire with address 0 is ignored.

**Hazard conditions** (`o_stall` is the OR of all of these)
- `i_rs1_en` and `i_rs1` ≠ 0 and `cnt[i_rs1]` ≠ 0.
- The same check for rs2.
- `i_issue_rd_en` and `cnt[i_issue_rd]` is saturated (all ones).
- `i_issue_load` and `lcnt` == `MAX_LOADS`.
- `i_load_stall`.
- `o_stall` is gated by `i_issue_valid`; it is 0 when there is no valid instruction.

**Issue and retire**
- `o_issue` = `i_issue_valid & ~o_stall`.
- There is no retire bypass. If a source register retires in the same cycle it is read, `o_stall` is still 1 that cycle, and the instruction issues on the following cycle.
- Counter update per register r, applied at the clock edge:
  - increment if (issue to r) and not (retire of r);
  - decrement if (retire of r) and not (issue to r);
  - otherwise hold.
  - "Issue to r" means `o_issue & i_issue_rd_en & i_issue_rd == r`. "Retire of r" means `i_rd_wvalid & i_rd_waddr == r`.
- `lcnt` update:
  - +1 on `o_issue & i_issue_load`;
  - −1 on `i_load_retire`;
  - hold when both occur in the same cycle.

**Errors**
- A retire to a register whose counter is 0 sets `err`; that counter stays 0.
- `i_load_retire` while `lcnt` == 0 sets `err`; `lcnt` stays 0.
- `err` clears only on reset.

**Outputs**
- `o_pending[r]` = (`cnt[r]` ≠ 0), taken from registered state.
- `o_loads_busy` = (`lcnt` == `MAX_LOADS`), taken from registered state.

## Timing

- **Reset:** while `rstn` = 0, all counters, `lcnt` and `err` are 0 asynchronously. Hence `o_pending` = 0, `o_loads_busy` = 0 and `o_err` = 0. `o_stall` and `o_issue` follow their combinational equations, which give 0 unless `i_issue_valid` is asserted. Reset may assert at any time, including mid-stall; in-flight tracking is discarded.
- **Combinational paths:** `o_stall` and `o_issue` respond in the same cycle as their inputs, with no register in between.
- **Visibility:** a counter change from an issue or retire shows on `o_pending` and in hazard checks in the cycle after the clock edge. An instruction can therefore issue in the cycle right after a producer issues only if it does not read that producer's destination.
- **Stall duration:** decode holds its inputs stable while `o_stall` = 1. The scoreboard imposes no minimum or maximum stall length.

## Test plan

1. **Reset.** Assert `rstn` = 0 in the middle of a sequence with `cnt[5]` = 2. → `o_pending` = 0 and `o_err` = 0 immediately. After release, `add x6, x5` issues on its first valid cycle.
2. **RAW hazard.** Issue `rd` = 3. Next cycle present `rs1` = 3. → `o_stall` = 1 until the cycle after `i_rd_wvalid` with `waddr` = 3. `o_issue` pulses exactly once, in that following cycle.
3. **Same-cycle issue and retire on x7.** Issue `rd` = 7 while retiring `waddr` = 7, with `cnt[7]` = 1. → `cnt[7]` stays 1 and `o_pending[7]` stays 1.
4. **Load limit.** Issue two loads (`rd` = 1, `rd` = 2) with no retire. → `o_loads_busy` = 1 and a third load stalls. One `i_load_retire` → the third load issues the next cycle.
5. **Load stall and x0.** Assert `i_load_stall` = 1 with no hazard → `o_stall` = 1. Issue with `rd` = 0 → `o_pending` = 0. Present `rs1` = 0 → no stall.
6. **Errors.** Retire `waddr` = 9 while `cnt[9]` = 0 → `o_err` = 1 the next cycle and it stays 1. Saturate `cnt[4]` to 3 → a further issue to `rd` = 4 stalls.

Source files
------------

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register-hazard scoreboard sitting between decode and write-back.
// Tracks how many issued-but-unwritten writes target each architectural register
// and holds decode while a source depends on one of them, while a destination
// counter is full, while the load window is full, or while write-back is
// waiting on load data.
//
// Ports:
//   clk, rstn           core clock, asynchronous active-low reset
//   i_issue_*           instruction presented by decode (valid, rd enable/addr, load)
//   i_rs1_en/i_rs1,     source operands read by the presented instruction
//   i_rs2_en/i_rs2
//   i_load_stall        write-back waiting on load data
//   i_rd_wvalid/waddr   write-back register-file write (retire of a tracked write)
//   i_load_retire       a load's data accepted by write-back
//   o_stall, o_issue    combinational hold / accept for the presented instruction
//   o_pending           per-register in-flight flags (bit 0 always 0)
//   o_loads_busy        outstanding-load window full
//   o_err               sticky protocol error (retire with nothing in flight)
module wb_scoreboard #(
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned MAX_LOADS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_issue_valid,
  input  logic        i_issue_rd_en,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_load,
  input  logic        i_rs1_en,
  input  logic        i_rs2_en,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic        i_load_stall,
  input  logic        i_rd_wvalid,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_load_retire,
  output logic        o_stall,
  output logic        o_issue,
  output logic [31:0] o_pending,
  output logic        o_loads_busy,
  output logic        o_err
);

  localparam int unsigned       LCNT_W   = $clog2(MAX_LOADS + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOADS);

  // Entry 0 exists only so lookups by raw address need no x0 special case;
  // it is held at zero, so x0 never hazards, saturates or shows as pending.
  logic [CNT_W-1:0]  cnt     [32];
  logic [CNT_W-1:0]  cnt_nxt [32];
  logic [LCNT_W-1:0] lcnt, lcnt_nxt;
  logic              err, err_nxt;
  logic              rs1_haz, rs2_haz, rd_full, ld_full;

  always_comb begin
    rs1_haz = i_rs1_en && (cnt[i_rs1] != '0);
    rs2_haz = i_rs2_en && (cnt[i_rs2] != '0);
    rd_full = i_issue_rd_en && (&cnt[i_issue_rd]);
    ld_full = i_issue_load && (lcnt == LCNT_MAX);
    o_stall = i_issue_valid && (rs1_haz || rs2_haz || rd_full || ld_full || i_load_stall);
    o_issue = i_issue_valid && !o_stall;
  end

  always_comb begin
    logic iss, ret;
    iss        = 1'b0;
    ret        = 1'b0;
    err_nxt    = err;
    cnt_nxt[0] = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      iss        = o_issue && i_issue_rd_en && (i_issue_rd == 5'(r));
      ret        = i_rd_wvalid && (i_rd_waddr == 5'(r));
      cnt_nxt[r] = cnt[r];
      if (ret && (cnt[r] == '0))
        err_nxt = 1'b1;
      if (iss && !ret)
        cnt_nxt[r] = cnt[r] + CNT_W'(1);
      else if (ret && !iss && (cnt[r] != '0))
        cnt_nxt[r] = cnt[r] - CNT_W'(1);
    end

    lcnt_nxt = lcnt;
    if (i_load_retire && (lcnt == '0))
      err_nxt = 1'b1;
    if (o_issue && i_issue_load && !i_load_retire)
      lcnt_nxt = lcnt + LCNT_W'(1);
    else if (i_load_retire && !(o_issue && i_issue_load) && (lcnt != '0))
      lcnt_nxt = lcnt - LCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < 32; r++)
        cnt[r] <= '0;
      lcnt <= '0;
      err  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 32; r++)
        cnt[r] <= cnt_nxt[r];
      lcnt <= lcnt_nxt;
      err  <= err_nxt;
    end
  end

  always_comb begin
    o_pending[0] = 1'b0;
    for (int unsigned r = 1; r < 32; r++)
      o_pending[r] = (cnt[r] != '0);
    o_loads_busy = (lcnt == LCNT_MAX);
    o_err        = err;
  end

endmodule
